// File: rtl/register_file.sv
// DEPTH x WIDTH register file: one byte-masked write port, two registered read ports.
// Build option REGFILE_BYPASS_EN: write-first reads on a collision (read-first when undefined).
module register_file #(
   parameter int               WIDTH       = 32,
   parameter int               DEPTH       = 16,
   parameter int               AW          = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter bit               ZERO_REG    = 1'b1
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Wr,
   input  logic [AW-1:0]      WrAddr,
   input  logic [WIDTH/8-1:0] ByteEn,
   input  logic [WIDTH-1:0]   Data_in,
   input  logic [AW-1:0]      RdAddrA,
   input  logic [AW-1:0]      RdAddrB,
   output logic [WIDTH-1:0]   Data_outA,
   output logic [WIDTH-1:0]   Data_outB
);

   localparam int NB = WIDTH / 8;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [WIDTH-1:0] rd_src [DEPTH];
   logic [WIDTH-1:0] rd_a_q, rd_a_d;
   logic [WIDTH-1:0] rd_b_q, rd_b_d;
   logic             wr_en;

   always_comb begin
      // Dropped writes never reach mem_d, so they can never bypass either.
      wr_en = Wr && (32'(WrAddr) < DEPTH) && !(ZERO_REG && (WrAddr == '0));
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
         if (wr_en && (WrAddr == AW'(i))) begin
            for (int b = 0; b < NB; b++) begin
               if (ByteEn[b]) begin
                  mem_d[i][8*b +: 8] = Data_in[8*b +: 8];
               end
            end
         end
`ifdef REGFILE_BYPASS_EN
         rd_src[i] = mem_d[i];
`else
         rd_src[i] = mem_q[i];
`endif
      end
   end

   // Entry 0 under ZERO_REG resets to 0 and is never written, so it always reads 0.
   always_comb begin
      rd_a_d = '0;
      rd_b_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (RdAddrA == AW'(i)) begin
            rd_a_d = rd_src[i];
         end
         if (RdAddrB == AW'(i)) begin
            rd_b_d = rd_src[i];
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= (ZERO_REG && (i == 0)) ? '0 : RESET_VALUE;
         end
         rd_a_q <= '0;
         rd_b_q <= '0;
      end else begin
         mem_q  <= mem_d;
         rd_a_q <= rd_a_d;
         rd_b_q <= rd_b_d;
      end
   end

   assign Data_outA = rd_a_q;
   assign Data_outB = rd_b_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench: two register_file instances (default, and DEPTH=12/no zero reg/nonzero reset) vs an array model.
module tb_register_file;

   localparam logic [31:0] RV1 = 32'hCAFE0001;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        wr;
   logic [3:0]  waddr;
   logic [3:0]  be;
   logic [31:0] din;
   logic [3:0]  ra, rb;
   logic [31:0] qa0, qb0, qa1, qb1;

   int checks = 0;
   int errors = 0;

   // Model: m0 follows the default instance, m1 the DEPTH=12 instance.
   logic [31:0] m0 [16];
   logic [31:0] m1 [16];

   always #5 clk = ~clk;

   register_file dut0 (
      .Clk(clk), .Reset(rst), .Wr(wr), .WrAddr(waddr), .ByteEn(be), .Data_in(din),
      .RdAddrA(ra), .RdAddrB(rb), .Data_outA(qa0), .Data_outB(qb0)
   );

   register_file #(.WIDTH(32), .DEPTH(12), .AW(4), .RESET_VALUE(RV1), .ZERO_REG(1'b0)) dut1 (
      .Clk(clk), .Reset(rst), .Wr(wr), .WrAddr(waddr), .ByteEn(be), .Data_in(din),
      .RdAddrA(ra), .RdAddrB(rb), .Data_outA(qa1), .Data_outB(qb1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                         input logic [3:0] mask);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = data[8*b +: 8];
      return r;
   endfunction

   // One clock edge with the current inputs; expectations come from the model.
   task automatic cycle(input string tag);
      logic [31:0] n0 [16];
      logic [31:0] n1 [16];
      logic [31:0] ea0, eb0, ea1, eb1;
      if (!rst) begin
         for (int i = 0; i < 16; i++) begin
            n0[i] = 32'h0;
            n1[i] = RV1;
         end
         ea0 = 0; eb0 = 0; ea1 = 0; eb1 = 0;
      end else begin
         n0 = m0;
         n1 = m1;
         if (wr && waddr != 0) n0[waddr] = merge(m0[waddr], din, be);
         if (wr && waddr < 12) n1[waddr] = merge(m1[waddr], din, be);
         ea0 = (ra == 0) ? 32'h0 : (BYP ? n0[ra] : m0[ra]);
         eb0 = (rb == 0) ? 32'h0 : (BYP ? n0[rb] : m0[rb]);
         ea1 = (ra >= 12) ? 32'h0 : (BYP ? n1[ra] : m1[ra]);
         eb1 = (rb >= 12) ? 32'h0 : (BYP ? n1[rb] : m1[rb]);
      end
      @(posedge clk);
      #1;
      check({tag, ".a0"}, qa0, ea0);
      check({tag, ".b0"}, qb0, eb0);
      check({tag, ".a1"}, qa1, ea1);
      check({tag, ".b1"}, qb1, eb1);
      m0 = n0;
      m1 = n1;
   endtask

   task automatic drive(input logic r, input logic w, input logic [3:0] wa, input logic [3:0] m,
                        input logic [31:0] d, input logic [3:0] a, input logic [3:0] b);
      rst = r; wr = w; waddr = wa; be = m; din = d; ra = a; rb = b;
   endtask

   initial begin
      // Reset has priority over a write in the same cycle.
      drive(1'b0, 1'b1, 4'd3, 4'hF, 32'hFFFFFFFF, 4'd3, 4'd3);
      cycle("reset_hold");
      check("reset_outA", qa0, 32'h0);
      drive(1'b1, 1'b0, 4'd3, 4'hF, 32'h0, 4'd3, 4'd3);
      cycle("post_reset");
      check("post_reset_a3", qa0, 32'h0);
      check("post_reset_rv", qb1, RV1);

      // Full-word write then read on both ports.
      drive(1'b1, 1'b1, 4'd5, 4'hF, 32'h55555555, 4'd0, 4'd0);
      cycle("wr5");
      drive(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 4'd5, 4'd6);
      cycle("rd5");
      check("full_word", qa0, 32'h55555555);
      check("neighbour", qb0, 32'h0);

      // Byte mask.
      drive(1'b1, 1'b1, 4'd5, 4'b1100, 32'hFFFF0000, 4'd0, 4'd0);
      cycle("mask5");
      drive(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 4'd5, 4'd5);
      cycle("rdmask5");
      check("byte_mask", qa0, 32'hFFFF5555);

      // Zero register.
      drive(1'b1, 1'b1, 4'd0, 4'hF, 32'h12345678, 4'd0, 4'd0);
      cycle("wr0");
      drive(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 4'd0, 4'd0);
      cycle("rd0");
      check("zero_reg", qa0, 32'h0);
      check("no_zero_reg", qa1, 32'h12345678);

      // Out of range on the DEPTH=12 instance.
      drive(1'b1, 1'b1, 4'd13, 4'hF, 32'hDEADBEEF, 4'd0, 4'd0);
      cycle("wr13");
      drive(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 4'd13, 4'd13);
      cycle("rd13");
      check("range_drop", qa1, 32'h0);
      check("in_range16", qa0, 32'hDEADBEEF);

      // Collision.
      drive(1'b1, 1'b1, 4'd7, 4'hF, 32'hAAAAAAAA, 4'd0, 4'd0);
      cycle("wr7");
      drive(1'b1, 1'b1, 4'd7, 4'hF, 32'h0000FFFF, 4'd7, 4'd5);
      cycle("collide7");
      check("collision", qa0, BYP ? 32'h0000FFFF : 32'hAAAAAAAA);
      drive(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 4'd7, 4'd7);
      cycle("after7");
      check("after_collision", qa0, 32'h0000FFFF);

      // Reset mid-operation.
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 1'b1, 4'(i), 4'hF, 32'h11111111 * i, 4'(i), 4'd0);
         cycle("fill");
      end
      drive(1'b0, 1'b0, 4'd0, 4'h0, 32'h0, 4'd1, 4'd2);
      cycle("mid_reset");
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 1'b0, 4'd0, 4'h0, 32'h0, 4'(i), 4'(i));
         cycle("rd_after_reset");
         check("mid_reset_a", qa0, 32'h0);
         check("mid_reset_b", qb1, RV1);
      end

      // Random traffic with frequent collisions.
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 49) != 0), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 3) == 0) ra = waddr;
         if ($urandom_range(0, 3) == 0) rb = waddr;
         cycle("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
